scratch_ram_slave: RTL and testbench

Memory-mapped scratchpad responder on the system bus: the target-side counterpart of the BIU initiator handshake. It decodes a word-addressed window at BASE_ADDR, holds DEPTH×DATA_WIDTH words, inserts a configurable number of wait states, and returns read data with a one-cycle valid strobe. Bus test masters use it as a fast, deterministic target alongside the SRAM and seg7 slaves.

---
 rtl/scratch_ram_slave_pkg.sv | 34 +++
 rtl/scratch_ram_slave.sv | 163 ++++++++++++++++
 tb/tb_scratch_ram_slave.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scratch_ram_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scratch_ram_slave_pkg
// Description : Shared definitions for the scratchpad bus slave: one-hot
//               access-state encoding, the system-bus slave base addresses,
//               and a helper that picks the first state of an access.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package scratch_ram_slave_pkg;

    // One-hot access states, 4 bits wide.
    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_WAIT = 4'b0010,
        S_XFER = 4'b0100,
        S_RESP = 4'b1000
    } state_t;

    // Word base addresses of the slaves on the system bus.
    localparam logic [31:0] c_sram_base_addr    = 32'hc000_0000;
    localparam logic [31:0] c_seg7_base_addr    = 32'hc000_1000;
    localparam logic [31:0] c_scratch_base_addr = 32'hc000_2000;

    // Width of the wait-state down-counter.
    localparam int c_wait_cnt_width = 4;

    // An accepted access goes through WAIT only when wait states are configured.
    function automatic state_t f_first_state(input int wait_states);
        return (wait_states > 0) ? S_WAIT : S_XFER;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scratch_ram_slave.sv
`default_nettype none
// ============================================================================
// Module      : scratch_ram_slave
// Description : Memory-mapped scratchpad responder. Decodes a word-addressed
//               window of DEPTH words at BASE_ADDR, inserts WAIT_STATES busy
//               cycles per access, and returns read data with a one-cycle
//               valid strobe.
// Ports       : clk          - clock, rising edge
//               n_rst        - asynchronous active-low reset
//               i_en         - request strobe
//               i_rnw        - 1 = read, 0 = write
//               i_address    - word address
//               i_wdata      - write data
//               o_busy       - access in progress, requests ignored
//               o_data_valid - one-cycle read-data strobe
//               o_rdata      - read data, held until the next read completes
// Revision    : 1.0 - initial release
// ============================================================================
module scratch_ram_slave
    import scratch_ram_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(c_scratch_base_addr),
    parameter int                    DEPTH       = 16,
    parameter int                    WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_en,
    input  logic                  i_rnw,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_busy,
    output logic                  o_data_valid,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int c_idx_width = $clog2(DEPTH);
    // Counter reload: WAIT is left when the counter is already zero, so
    // loading WAIT_STATES-1 yields exactly WAIT_STATES cycles in WAIT.
    localparam logic [c_wait_cnt_width-1:0] c_wait_load =
        (WAIT_STATES > 0) ? c_wait_cnt_width'(WAIT_STATES - 1) : '0;
    localparam state_t c_first_state = f_first_state(WAIT_STATES);

    state_t                        r_state;
    state_t                        w_next_state;
    logic [c_wait_cnt_width-1:0]   r_wait_cnt;
    logic                          r_rnw;
    logic [c_idx_width-1:0]        r_idx;
    logic [DATA_WIDTH-1:0]         r_wdata;
    logic [DATA_WIDTH-1:0]         r_rdata;
    logic [DATA_WIDTH-1:0]         r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0]         w_offset;
    logic                          w_hit;
    logic                          w_can_accept;
    logic                          w_accept;

    // Unsigned offset into the window; addresses below BASE_ADDR wrap to a
    // large offset and therefore miss.
    assign w_offset     = i_address - BASE_ADDR;
    assign w_hit        = (w_offset < ADDR_WIDTH'(DEPTH));
    // Not busy in IDLE and RESP, so a new access can start on the RESP cycle.
    assign w_can_accept = (r_state == S_IDLE) || (r_state == S_RESP);
    assign w_accept     = i_en && w_can_accept && w_hit;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = c_first_state;
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_next_state = S_XFER;
                end
            end
            S_XFER: begin
                w_next_state = r_rnw ? S_RESP : S_IDLE;
            end
            S_RESP: begin
                w_next_state = w_accept ? c_first_state : S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: both strobes come straight from state flops.
    // ------------------------------------------------------------------
    always_comb begin
        o_busy       = 1'b0;
        o_data_valid = 1'b0;
        case (r_state)
            S_WAIT, S_XFER: o_busy       = 1'b1;
            S_RESP:         o_data_valid = 1'b1;
            default: ;
        endcase
    end

    assign o_rdata = r_rdata;

    // ------------------------------------------------------------------
    // Request capture, wait counter and read-data register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wait_cnt <= '0;
            r_rnw      <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_accept) begin
                r_rnw      <= i_rnw;
                r_idx      <= w_offset[c_idx_width-1:0];
                r_wdata    <= i_wdata;
                r_wait_cnt <= c_wait_load;
            end else if ((r_state == S_WAIT) && (r_wait_cnt != '0)) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end

            if ((r_state == S_XFER) && r_rnw) begin
                r_rdata <= r_mem[r_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage array, cleared on reset. A reset during an access returns
    // the FSM to IDLE before XFER, so no write is committed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if ((r_state == S_XFER) && !r_rnw) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scratch_ram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_scratch_ram_slave
// Description : Self-checking bench for scratch_ram_slave. Instance 0 uses
//               one wait state, instance 1 uses none. Expected values come
//               from a word-array model and the access timing rules.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scratch_ram_slave;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'hc000_2000;

    logic        clk   = 1'b0;
    logic        n_rst = 1'b0;
    logic        en    [2];
    logic        rnw   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        busy  [2];
    logic        dv    [2];
    logic [31:0] rdata [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference contents of each instance.
    logic [31:0] model [2][DEPTH];

    always #5 clk = ~clk;

    scratch_ram_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE),
        .DEPTH(DEPTH), .WAIT_STATES(1)
    ) dut_ws1 (
        .clk(clk), .n_rst(n_rst), .i_en(en[0]), .i_rnw(rnw[0]),
        .i_address(addr[0]), .i_wdata(wdata[0]), .o_busy(busy[0]),
        .o_data_valid(dv[0]), .o_rdata(rdata[0])
    );

    scratch_ram_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE),
        .DEPTH(DEPTH), .WAIT_STATES(0)
    ) dut_ws0 (
        .clk(clk), .n_rst(n_rst), .i_en(en[1]), .i_rnw(rnw[1]),
        .i_address(addr[1]), .i_wdata(wdata[1]), .o_busy(busy[1]),
        .o_data_valid(dv[1]), .o_rdata(rdata[1])
    );

    function automatic int ws_of(input int s);
        return (s == 0) ? 1 : 0;
    endfunction

    function automatic bit is_hit(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(DEPTH);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off % 32'(DEPTH));
    endfunction

    // Busy is expected in cycles 1..ws+1 after the accepting edge.
    function automatic logic [8:0] busy_mask(input int s);
        return 9'(((1 << (ws_of(s) + 1)) - 1) << 1);
    endfunction

    task automatic clear_models();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++)
                model[s][i] = '0;
    endtask

    // Presents one request for a single edge, then observes 8 cycles.
    task automatic access(input int s, input bit r, input logic [31:0] a,
                          input logic [31:0] d, output logic [8:0] bmask,
                          output int vcyc, output int vcnt, output logic [31:0] rd);
        @(negedge clk);
        en[s] = 1'b1; rnw[s] = r; addr[s] = a; wdata[s] = d;
        @(posedge clk); #1;
        en[s] = 1'b0;
        bmask = '0; vcyc = -1; vcnt = 0; rd = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            bmask[k] = busy[s];
            if (dv[s]) begin
                vcnt++;
                if (vcyc < 0) vcyc = k;
                rd = rdata[s];
            end
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            n_checks++;
            if (busy[s] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b, want 0", s, busy[s]); end
            n_checks++;
            if (dv[s] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b, want 0", s, dv[s]); end
            n_checks++;
            if (rdata[s] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h, want 0", s, rdata[s]); end
        end
        n_rst = 1'b1;
        clear_models();
    endtask

    task automatic test_write_read();
        logic [8:0] bm; int vc, vn; logic [31:0] rd;
        access(0, 1'b0, BASE + 5, 32'hdeadbeef, bm, vc, vn, rd);
        model[0][5] = 32'hdeadbeef;
        n_checks++;
        if (bm !== 9'b0_0000_0110) begin n_fail++; $display("FAIL wr_busy: mask %b, want %b", bm, 9'b0_0000_0110); end
        n_checks++;
        if (vn !== 0) begin n_fail++; $display("FAIL wr_novalid: %0d pulses, want 0", vn); end
        access(0, 1'b1, BASE + 5, 32'h0, bm, vc, vn, rd);
        n_checks++;
        if (vc !== 3 || vn !== 1) begin n_fail++; $display("FAIL rd_valid_cycle: cycle %0d count %0d, want cycle 3 count 1", vc, vn); end
        n_checks++;
        if (rd !== 32'hdeadbeef) begin n_fail++; $display("FAIL rd_data: got %h, want deadbeef", rd); end
        n_checks++;
        if (bm !== busy_mask(0)) begin n_fail++; $display("FAIL rd_busy: mask %b, want %b", bm, busy_mask(0)); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] bm; int vc, vn; logic [31:0] rd;
        int got, cyc, last, idx_req;
        bit adv;
        for (int i = 0; i < DEPTH; i++) begin
            access(0, 1'b0, BASE + 32'(i), 32'(i) * 32'h1111_1111, bm, vc, vn, rd);
            model[0][i] = 32'(i) * 32'h1111_1111;
            n_checks++;
            if (vn !== 0 || bm !== busy_mask(0)) begin
                n_fail++; $display("FAIL fill_wr[%0d]: valid %0d busy %b, want 0 / %b", i, vn, bm, busy_mask(0));
            end
        end
        // Keep i_en high; each new address is taken on the RESP cycle of
        // the previous read, so valid pulses must be ws+2 cycles apart.
        @(negedge clk);
        en[0] = 1'b1; rnw[0] = 1'b1; addr[0] = BASE;
        @(posedge clk); #1;
        idx_req = 1; addr[0] = BASE + 32'd1;
        got = 0; cyc = 0; last = -1;
        while (got < DEPTH && cyc < 200) begin
            @(negedge clk);
            cyc++;
            adv = 1'b0;
            if (dv[0]) begin
                n_checks++;
                if (rdata[0] !== model[0][got]) begin
                    n_fail++; $display("FAIL b2b_data[%0d]: got %h, want %h", got, rdata[0], model[0][got]);
                end
                n_checks++;
                if ((last < 0 && cyc != ws_of(0) + 2) || (last >= 0 && cyc - last != ws_of(0) + 2)) begin
                    n_fail++; $display("FAIL b2b_gap[%0d]: valid at cycle %0d, previous %0d, period want %0d", got, cyc, last, ws_of(0) + 2);
                end
                last = cyc;
                got++;
                adv = 1'b1;
            end
            @(posedge clk); #1;
            if (adv) begin
                idx_req++;
                if (idx_req < DEPTH) addr[0] = BASE + 32'(idx_req);
                else en[0] = 1'b0;
            end
        end
        en[0] = 1'b0;
        n_checks++;
        if (got !== DEPTH) begin n_fail++; $display("FAIL b2b_count: %0d reads returned, want %0d", got, DEPTH); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_miss();
        logic [8:0] bm; int vc, vn; logic [31:0] rd;
        logic [31:0] miss_a [2];
        miss_a[0] = BASE + 32'd16;
        miss_a[1] = BASE - 32'd1;
        for (int m = 0; m < 2; m++) begin
            access(0, 1'b0, miss_a[m], 32'hbad0_bad0, bm, vc, vn, rd);
            n_checks++;
            if (bm !== 9'b0 || vn !== 0) begin n_fail++; $display("FAIL miss_wr[%0d]: busy %b valid %0d, want 0 / 0", m, bm, vn); end
            access(0, 1'b1, miss_a[m], 32'h0, bm, vc, vn, rd);
            n_checks++;
            if (bm !== 9'b0 || vn !== 0) begin n_fail++; $display("FAIL miss_rd[%0d]: busy %b valid %0d, want 0 / 0", m, bm, vn); end
        end
        access(0, 1'b1, BASE, 32'h0, bm, vc, vn, rd);
        n_checks++;
        if (vn !== 1 || rd !== model[0][0]) begin n_fail++; $display("FAIL miss_keep0: got %h (valid %0d), want %h", rd, vn, model[0][0]); end
        access(0, 1'b1, BASE + 32'd15, 32'h0, bm, vc, vn, rd);
        n_checks++;
        if (vn !== 1 || rd !== model[0][15]) begin n_fail++; $display("FAIL miss_keep15: got %h (valid %0d), want %h", rd, vn, model[0][15]); end
    endtask

    task automatic test_busy_ignore();
        logic [8:0] bm; int vc, vn; logic [31:0] rd;
        @(negedge clk);
        en[0] = 1'b1; rnw[0] = 1'b1; addr[0] = BASE + 32'd5;
        @(posedge clk); #1;
        // Second request, a write, presented while the read is in WAIT.
        rnw[0] = 1'b0; addr[0] = BASE + 32'd6; wdata[0] = 32'h0bad_f00d;
        bm = '0; vn = 0; rd = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            bm[k] = busy[0];
            if (dv[0]) begin vn++; rd = rdata[0]; end
            if (k == 1) begin @(posedge clk); #1; en[0] = 1'b0; end
        end
        n_checks++;
        if (vn !== 1) begin n_fail++; $display("FAIL busy_pulses: %0d valid pulses, want 1", vn); end
        n_checks++;
        if (rd !== model[0][5]) begin n_fail++; $display("FAIL busy_rdata: got %h, want %h", rd, model[0][5]); end
        n_checks++;
        if (bm !== busy_mask(0)) begin n_fail++; $display("FAIL busy_mask: mask %b, want %b", bm, busy_mask(0)); end
        access(0, 1'b1, BASE + 32'd6, 32'h0, bm, vc, vn, rd);
        n_checks++;
        if (rd !== model[0][6]) begin n_fail++; $display("FAIL busy_nowrite: idx6 %h, want %h", rd, model[0][6]); end
    endtask

    task automatic test_random();
        logic [8:0] bm; int vc, vn; logic [31:0] rd;
        logic [31:0] a, d;
        bit r, h;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0:       a = BASE + 32'd16 + 32'($urandom_range(0, 1000));
                1:       a = BASE - 32'd1 - 32'($urandom_range(0, 1000));
                default: a = BASE + 32'($urandom_range(0, DEPTH - 1));
            endcase
            r = 1'($urandom_range(0, 1));
            d = $urandom;
            h = is_hit(a);
            access(0, r, a, d, bm, vc, vn, rd);
            n_checks++;
            if (bm !== (h ? busy_mask(0) : 9'b0)) begin
                n_fail++; $display("FAIL rnd_busy[%0d]: addr %h mask %b, want %b", i, a, bm, h ? busy_mask(0) : 9'b0);
            end
            n_checks++;
            if (vn !== ((h && r) ? 1 : 0)) begin
                n_fail++; $display("FAIL rnd_valid[%0d]: addr %h rnw %b pulses %0d", i, a, r, vn);
            end
            if (h && r) begin
                n_checks++;
                if (rd !== model[0][idx_of(a)] || vc !== ws_of(0) + 2) begin
                    n_fail++; $display("FAIL rnd_rdata[%0d]: addr %h got %h at cycle %0d, want %h at %0d", i, a, rd, vc, model[0][idx_of(a)], ws_of(0) + 2);
                end
            end
            if (h && !r) model[0][idx_of(a)] = d;
        end
    endtask

    task automatic test_reset_mid_access();
        logic [8:0] bm; int vc, vn; logic [31:0] rd;
        access(0, 1'b0, BASE + 32'd3, 32'ha5a5_0003, bm, vc, vn, rd);
        model[0][3] = 32'ha5a5_0003;
        access(0, 1'b1, BASE + 32'd3, 32'h0, bm, vc, vn, rd);
        n_checks++;
        if (rd !== 32'ha5a5_0003) begin n_fail++; $display("FAIL mid_pre: got %h, want a5a50003", rd); end
        @(negedge clk);
        en[0] = 1'b1; rnw[0] = 1'b1; addr[0] = BASE + 32'd3;
        @(posedge clk); #1;
        en[0] = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        n_checks++;
        if (busy[0] !== 1'b0 || dv[0] !== 1'b0 || rdata[0] !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset_out: busy %b valid %b rdata %h, want 0 0 0", busy[0], dv[0], rdata[0]);
        end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        clear_models();
        access(0, 1'b1, BASE + 32'd3, 32'h0, bm, vc, vn, rd);
        n_checks++;
        if (vn !== 1 || rd !== 32'h0) begin n_fail++; $display("FAIL mid_after: idx3 %h (valid %0d), want 0", rd, vn); end
    endtask

    task automatic test_ws0();
        logic [8:0] bm; int vc, vn; logic [31:0] rd;
        logic [31:0] v;
        access(1, 1'b0, BASE, 32'h1234, bm, vc, vn, rd);
        model[1][0] = 32'h1234;
        n_checks++;
        if (bm !== 9'b0_0000_0010 || vn !== 0) begin n_fail++; $display("FAIL ws0_wr: busy %b valid %0d, want 000000010 / 0", bm, vn); end
        access(1, 1'b1, BASE, 32'h0, bm, vc, vn, rd);
        n_checks++;
        if (bm !== 9'b0_0000_0010 || vc !== 2) begin n_fail++; $display("FAIL ws0_rd_timing: busy %b valid cycle %0d, want 000000010 / 2", bm, vc); end
        n_checks++;
        if (rd !== 32'h1234) begin n_fail++; $display("FAIL ws0_rd_data: got %h, want 00001234", rd); end
        // Write then a read of the same word held pending: the read is taken
        // on the first non-busy cycle and must see the new value.
        v = $urandom;
        @(negedge clk);
        en[1] = 1'b1; rnw[1] = 1'b0; addr[1] = BASE + 32'd9; wdata[1] = v;
        @(posedge clk); #1;
        rnw[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        en[1] = 1'b0;
        model[1][9] = v;
        vn = 0; vc = -1; rd = '0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (dv[1]) begin vn++; if (vc < 0) vc = k; rd = rdata[1]; end
        end
        n_checks++;
        if (vn !== 1 || vc !== 2 || rd !== model[1][9]) begin
            n_fail++; $display("FAIL ws0_raw: got %h at cycle %0d (%0d pulses), want %h at cycle 2", rd, vc, vn, model[1][9]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            en[s] = 1'b0; rnw[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
        end
        clear_models();
        test_reset();
        test_write_read();
        test_back_to_back();
        test_miss();
        test_busy_ignore();
        test_random();
        test_reset_mid_access();
        test_ws0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
